// File: rtl/position_histogram.sv
// rtl/position_histogram.sv - dual-axis (y/x) 128-bin position histogram with framed readout
//
// Purpose: counts detector position events into a y-axis and an x-axis
// histogram over a frame of FRAME_CYCLES enabled cycles. At frame end the bins
// are frozen for SNAP_CYCLES cycles while start_sending is high, so the USB
// controller can copy them. The bins are then cleared for one cycle, and the
// next frame starts.
//
// Ports:
//   clk, reset_n         - clock, asynchronous active-low reset
//   acquire_en           - enables the frame timer and event counting
//   event_valid          - one detector event this cycle
//   event_y / event_x    - bin addresses of the event
//   read_index_yaxis/x   - readout addresses from the USB controller
//   data_yaxis/xaxis     - combinational bin read data
//   start_sending        - high while the bins are frozen for readout
//   frame_count          - completed frames, wraps
//   dropped_count        - events seen during HOLD/CLEAR, saturates
//
// Build option: define HIST_SATURATE_EN to make bins saturate at 16'hFFFF
// instead of wrapping to 0.

module position_histogram #(
    parameter int FRAME_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        acquire_en,
    input  logic        event_valid,
    input  logic [6:0]  event_y,
    input  logic [6:0]  event_x,
    input  logic [6:0]  read_index_yaxis,
    input  logic [6:0]  read_index_xaxis,
    output logic [15:0] data_yaxis,
    output logic [15:0] data_xaxis,
    output logic        start_sending,
    output logic [15:0] frame_count,
    output logic [15:0] dropped_count
);
    localparam int SNAP_CYCLES = 136;
    localparam int TIMER_W     = $clog2(FRAME_CYCLES);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(FRAME_CYCLES - 1);
    localparam logic [7:0]         HOLD_LAST  = 8'(SNAP_CYCLES - 1);

    typedef enum logic [1:0] {
        ACCUMULATE,
        HOLD,
        CLEAR
    } state_t;

    state_t             state;
    logic [TIMER_W-1:0] timer;
    logic [7:0]         hold_cnt;
    logic [15:0]        y_bin [128];
    logic [15:0]        x_bin [128];
    logic               count_event;

    assign count_event = (state == ACCUMULATE) && acquire_en && event_valid;
    assign data_yaxis  = y_bin[read_index_yaxis];
    assign data_xaxis  = x_bin[read_index_xaxis];

    function automatic logic [15:0] bump(input logic [15:0] v);
`ifdef HIST_SATURATE_EN
        return (v == 16'hFFFF) ? v : v + 16'd1;
`else
        return v + 16'd1;
`endif
    endfunction

    // Bin storage. Both axes update in the same cycle, independently, so an
    // event touches exactly one y bin and one x bin.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 128; i++) begin
                y_bin[i] <= '0;
                x_bin[i] <= '0;
            end
        end else if (state == CLEAR) begin
            for (int i = 0; i < 128; i++) begin
                y_bin[i] <= '0;
                x_bin[i] <= '0;
            end
        end else if (count_event) begin
            y_bin[event_y] <= bump(y_bin[event_y]);
            x_bin[event_x] <= bump(x_bin[event_x]);
        end
    end

    // Frame sequencer. start_sending is registered together with the state,
    // so it is high for exactly the cycles spent in HOLD.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= ACCUMULATE;
            timer         <= '0;
            hold_cnt      <= '0;
            start_sending <= 1'b0;
            frame_count   <= '0;
            dropped_count <= '0;
        end else begin
            case (state)
                ACCUMULATE: begin
                    if (acquire_en) begin
                        if (timer == TIMER_LAST) begin
                            state         <= HOLD;
                            start_sending <= 1'b1;
                            hold_cnt      <= '0;
                            frame_count   <= frame_count + 16'd1;
                        end else begin
                            timer <= timer + 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (hold_cnt == HOLD_LAST) begin
                        state         <= CLEAR;
                        start_sending <= 1'b0;
                    end else begin
                        hold_cnt <= hold_cnt + 8'd1;
                    end
                end
                CLEAR: begin
                    timer <= '0;
                    state <= ACCUMULATE;
                end
                default: begin
                    state         <= ACCUMULATE;
                    start_sending <= 1'b0;
                end
            endcase

            // Events outside ACCUMULATE are lost whatever acquire_en says.
            if (event_valid && (state != ACCUMULATE) && (dropped_count != 16'hFFFF)) begin
                dropped_count <= dropped_count + 16'd1;
            end
        end
    end
endmodule
